tx_block: RTL
=============

Name: tx_block

Overview:
UART-style serial transmitter, the sending end of the rcv_block link. Accepts 8-bit bytes over a parallel ready/load handshake and serialises each one as: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Two-stage buffering allows back-to-back frames with no idle gap:
- a 1-entry holding register
- a shift register
Sits on the transmit side of the serial interface; its serial_out drives rcv_block serial_in directly.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit; legal range 2..255; counter width = clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  synchronous active-low reset, sampled on rising clk.
tx_data  input  8  byte to transmit; sampled when tx_load=1.
tx_load  input  1  load request, single-cycle qualifier for tx_data.
err_clear  input  1  clears sticky load_error.
serial_out  output  1  serial line; idle high.
tx_ready  output  1  1 = holding register empty, load will be accepted.
tx_busy  output  1  1 = frame in progress (FSM not IDLE).
load_error  output  1  sticky; a load was attempted while tx_ready=0.

Behaviour:
- Reset (n_rst=0 at a rising edge), applies mid-frame too:
  - serial_out=1, tx_ready=1, tx_busy=0, load_error=0.
  - FSM to IDLE; holding register emptied; bit counter and cycle counter cleared.
  - Any frame in progress is abandoned; line returns high after that edge.
- Handshake:
  - Load accepted when tx_load=1 and tx_ready=1 at an edge: tx_data captured into holding, tx_ready=0 after that edge.
  - Load with tx_ready=0: byte dropped, holding unchanged, load_error=1 after that edge.
  - load_error stays 1 until an edge with err_clear=1.
  - A reject and err_clear at the same edge: error wins (load_error stays 1).
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - serial_out=1, tx_busy=0.
  - If holding full at an edge: transfer holding to shift register, holding emptied (tx_ready=1), go to START.
- START:
  - serial_out=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - serial_out = shift[bit index], each bit held CLKS_PER_BIT cycles.
  - After bit 7's final cycle, go to STOP.
- STOP:
  - serial_out=1 for CLKS_PER_BIT cycles.
  - On the final cycle, if holding full: transfer and go directly to START (no idle cycle); otherwise go to IDLE.
- Latency: accepted load at edge k (FSM in IDLE, holding empty) → transfer at edge k+1 → serial_out falls after edge k+1. tx_ready returns to 1 after edge k+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Load/transfer collision: a transfer only occurs with holding full (tx_ready=0), so it can never coincide with an accepted load. A load on the same edge as a transfer is rejected and sets load_error.
- The shift register is not disturbed by holding-register loads during a frame.
- serial_out is registered (glitch-free), driven from FSM/shift state only.
- tx_busy = (state != IDLE), registered alongside state.

Test Plan:
1. Reset: hold n_rst=0 for 2 edges with tx_load=1 → serial_out=1, tx_ready=1, tx_busy=0, load_error=0. No load is captured during reset.
2. Single frame: CLKS_PER_BIT=10, load 0xD5 at edge k → serial_out=0 for cycles k+1..k+10. Then 1,0,1,0,1,0,1,1 (10 cycles each), stop=1 for 10 cycles. tx_busy high for exactly 100 cycles, then IDLE.
3. Back-to-back: load 0xD5, then 0x3C once tx_ready=1 (mid-frame) → second start bit begins the cycle after the first stop bit ends. 200 contiguous busy cycles; second data bits 0,0,1,1,1,1,0,0.
4. Overload: load 0xD5, 0x3C, then 0xFF while tx_ready=0 → load_error=1, 0xFF never transmitted, 0x3C sent intact. err_clear=1 for 1 cycle → load_error=0. err_clear concurrent with another reject → load_error stays 1.
5. Reset mid-frame: assert n_rst=0 during DATA bit 3 → serial_out=1 after that edge, tx_ready=1, tx_busy=0. A subsequent load of 0x5A transmits cleanly.
6. Loopback: tx_block.serial_out → rcv_block.serial_in, both CLKS_PER_BIT=10. Send 0xA5 → rx_data=0xA5, data_ready=1, framing_error=0, overrun_error=0. Repeat back-to-back 0x00, 0xFF with data_read pulsed between them → both received with no errors.

Source files
------------

// File: rtl/tx_block.sv
// ============================================================================
// Module   : tx_block
// Purpose  : UART-style serial transmitter (start, 8 data LSB first, stop)
//            with a 1-entry holding register feeding a shift register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_block #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  input  logic       err_clear,
  output logic       serial_out,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       load_error
);

  localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             serial_q;
  logic             busy_q;
  logic             err_q;

  logic w_cnt_last;
  logic w_accept;
  logic w_reject;
  logic w_xfer;

  assign w_cnt_last = (cnt_q == CNT_LAST);
  assign w_accept   = tx_load & ~hold_full_q;
  assign w_reject   = tx_load &  hold_full_q;
  // Transfers need a full holding register, so they never collide with an accepted load.
  assign w_xfer     = hold_full_q &
                      ((state_q == IDLE) | ((state_q == STOP) & w_cnt_last));

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_idx_q   <= 3'd0;
      cnt_q       <= '0;
      serial_q    <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (w_reject) begin
        err_q <= 1'b1;
      end else if (err_clear) begin
        err_q <= 1'b0;
      end

      if (w_xfer) begin
        hold_full_q <= 1'b0;
      end else if (w_accept) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (w_xfer) begin
            shift_q  <= hold_q;
            state_q  <= START;
            busy_q   <= 1'b1;
            serial_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        START: begin
          if (w_cnt_last) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            state_q   <= DATA;
            serial_q  <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_cnt_last) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q  <= STOP;
              serial_q <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (w_cnt_last) begin
            cnt_q <= '0;
            // A waiting byte starts immediately so back-to-back frames stay contiguous.
            if (w_xfer) begin
              shift_q  <= hold_q;
              state_q  <= START;
              serial_q <= 1'b0;
            end else begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              serial_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

  assign serial_out = serial_q;
  assign tx_ready   = ~hold_full_q;
  assign tx_busy    = busy_q;
  assign load_error = err_q;

endmodule

`default_nettype wire
